// File: rtl/cam_tlb_rr.sv
// Fully associative TLB CAM (VPN tag -> PFN payload) with registered lookup, round-robin
// auto-replacement that prefers free lines, invalidate-by-tag and a sequenced flush.
module cam_tlb_rr #(
  parameter  int DEPTH  = 8,
  parameter  int TAG_W  = 20,
  parameter  int DATA_W = 20,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit_valid,
  output logic              hit,
  output logic              multi_hit,
  output logic [IDX_W-1:0]  maddress,
  output logic [DATA_W-1:0] mdata,
  input  logic              wren,
  input  logic              wr_auto,
  input  logic [IDX_W-1:0]  wraddress,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [TAG_W-1:0]  inv_tag,
  input  logic              flush,
  output logic              busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state;
  logic [DEPTH-1:0]   valid;
  logic [TAG_W-1:0]   tags    [DEPTH];
  logic [DATA_W-1:0]  payload [DEPTH];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   flush_cnt;

  logic [DEPTH-1:0]   lk_match;
  logic [DEPTH-1:0]   wr_match;
  logic [DEPTH-1:0]   inv_match;
  logic [IDX_W-1:0]   lk_idx;
  logic [IDX_W-1:0]   wr_hit_idx;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               wr_hit_any;
  logic               free_any;
  logic               lk_multi;
  logic               do_inv;
  logic               do_wr;

  always_comb begin
    lk_match  = '0;
    wr_match  = '0;
    inv_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i]  = valid[i] && (tags[i] == lookup_tag);
      wr_match[i]  = valid[i] && (tags[i] == wr_tag);
      inv_match[i] = valid[i] && (tags[i] == inv_tag);
    end
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    lk_idx     = '0;
    wr_hit_idx = '0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (lk_match[i]) lk_idx = IDX_W'(i);
      if (wr_match[i]) wr_hit_idx = IDX_W'(i);
      if (!valid[i])   free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    wr_hit_any = |wr_match;
    free_any   = ~&valid;
    lk_multi   = (lk_match & (lk_match - DEPTH'(1))) != '0;
    if (!wr_auto)        victim = wraddress;
    else if (wr_hit_any) victim = wr_hit_idx;
    else if (free_any)   victim = free_idx;
    else                 victim = rr_ptr;
    do_inv = (state == IDLE) && !flush && inv_en;
    do_wr  = (state == IDLE) && !flush && !inv_en && wren;
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      tags[victim]    <= wr_tag;
      payload[victim] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      rr_ptr    <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      multi_hit <= 1'b0;
      maddress  <= '0;
      mdata     <= '0;
    end else begin
      hit_valid <= lookup_en;
      if (lookup_en) begin
        if (state == FLUSH || lk_match == '0) begin
          hit       <= 1'b0;
          multi_hit <= 1'b0;
          maddress  <= '0;
          mdata     <= '0;
        end else begin
          hit       <= 1'b1;
          multi_hit <= lk_multi;
          maddress  <= lk_idx;
          mdata     <= payload[lk_idx];
        end
      end

      if (state == IDLE) begin
        if (flush) begin
          state     <= FLUSH;
          busy      <= 1'b1;
          flush_cnt <= '0;
          rr_ptr    <= '0;
        end else if (do_inv) begin
          valid <= valid & ~inv_match;
        end else if (do_wr) begin
          valid[victim] <= 1'b1;
          // Only a full array with no tag match consumes the round-robin slot.
          if (wr_auto && !wr_hit_any && !free_any) rr_ptr <= rr_ptr + 1'b1;
        end
      end else begin
        valid[flush_cnt] <= 1'b0;
        flush_cnt        <= flush_cnt + 1'b1;
        if (flush_cnt == IDX_W'(DEPTH - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule
